// File: rtl/padd_pipe.sv
// Pipelined adder: one CHUNK-bit slice per stage, registered carries between stages,
// global valid/ready stall. Optional macro PADD_APPROX_EN adds an approx input.
module padd_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
`ifdef PADD_APPROX_EN
    ,
    input  logic             approx
`endif
);
    localparam int unsigned NSTG = (WIDTH + CHUNK - 1) / CHUNK;
    localparam logic [WIDTH:0] One = {{WIDTH{1'b0}}, 1'b1};

    logic [NSTG-1:0]  v_q, v_d;
    logic [NSTG-1:0]  c_q, c_d;
    logic [NSTG-1:0]  x_q, x_d;
    logic [WIDTH-1:0] a_q [NSTG];
    logic [WIDTH-1:0] a_d [NSTG];
    logic [WIDTH-1:0] b_q [NSTG];
    logic [WIDTH-1:0] b_d [NSTG];
    logic [WIDTH-1:0] s_q [NSTG];
    logic [WIDTH-1:0] s_d [NSTG];
    logic             ovf_q, ovf_d;
    logic             en;
    logic             approx_in;

`ifdef PADD_APPROX_EN
    assign approx_in = approx;
`else
    assign approx_in = 1'b0;
`endif

    assign en       = !v_q[NSTG-1] || out_ready;
    assign in_ready = en;

    always_comb begin
        logic [WIDTH-1:0] src_a, src_b, src_s;
        logic             src_c;
        logic [WIDTH:0]   mask, part, placed;
        int unsigned      lo, cw;
        v_d   = '0;
        c_d   = '0;
        x_d   = '0;
        ovf_d = 1'b0;
        for (int k = 0; k < int'(NSTG); k++) begin
            lo = CHUNK * unsigned'(k);
            cw = (unsigned'(k) == NSTG - 1) ? WIDTH - lo : CHUNK;
            if (k == 0) begin
                src_a  = a;
                src_b  = b;
                src_s  = '0;
                src_c  = cin;
                v_d[k] = in_valid;
                x_d[k] = approx_in;
            end else begin
                src_a  = a_q[k-1];
                src_b  = b_q[k-1];
                src_s  = s_q[k-1];
                // approx beats sever every inter-chunk carry
                src_c  = c_q[k-1] & ~x_q[k-1];
                v_d[k] = v_q[k-1];
                x_d[k] = x_q[k-1];
            end
            mask   = (One << cw) - One;
            part   = (({1'b0, src_a} >> lo) & mask) + (({1'b0, src_b} >> lo) & mask)
                   + {{WIDTH{1'b0}}, src_c};
            placed = (part & mask) << lo;
            a_d[k] = src_a;
            b_d[k] = src_b;
            s_d[k] = src_s | placed[WIDTH-1:0];
            c_d[k] = |((part >> cw) & One);
        end
        ovf_d = (a_d[NSTG-1][WIDTH-1] == b_d[NSTG-1][WIDTH-1]) &&
                (s_d[NSTG-1][WIDTH-1] != a_d[NSTG-1][WIDTH-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            c_q   <= '0;
            x_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < int'(NSTG); k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (en) begin
            v_q   <= v_d;
            c_q   <= c_d;
            x_q   <= x_d;
            ovf_q <= ovf_d;
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
        end
    end

    assign out_valid = v_q[NSTG-1];
    assign sum       = s_q[NSTG-1];
    assign cout      = c_q[NSTG-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_padd_pipe.sv
// Bench for padd_pipe: random traffic scored against a queue-based arithmetic model,
// plus directed latency, stall, reset and (with PADD_APPROX_EN) approximate-mode cases.
module tb_padd_pipe;
    localparam int unsigned W     = 32;
    localparam int unsigned CHUNK = 5;
    localparam int unsigned NSTG  = (W + CHUNK - 1) / CHUNK;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, cin, out_valid, out_ready, cout, ovf, ap;
    logic [W-1:0] a, b, sum;
    int           checks = 0;
    int           errors = 0;
    res_t         exp_q[$];
    logic         stall_prev = 1'b0;
    res_t         prev;

    always #5 clk = ~clk;

    padd_pipe #(.WIDTH(W), .CHUNK(CHUNK)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
`ifdef PADD_APPROX_EN
        ,
        .approx   (ap)
`endif
    );

    // Exact: plain wide addition. Approx: each chunk added on its own, cin only into chunk 0.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic apx);
        res_t        r;
        logic [W:0]  full;
        r = '0;
        if (!apx) begin
            full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
            r.s  = full[W-1:0];
            r.c  = full[W];
        end else begin
            for (int k = 0; k < int'(NSTG); k++) begin
                longint unsigned lo, w, m, t;
                lo  = 64'(k) * 64'(CHUNK);
                w   = (k == int'(NSTG) - 1) ? 64'(W) - lo : 64'(CHUNK);
                m   = (64'd1 << w) - 64'd1;
                t   = ((64'(x) >> lo) & m) + ((64'(y) >> lo) & m) + ((k == 0) ? 64'(ci) : 64'd0);
                r.s = r.s | W'((t & m) << lo);
                r.c = ((t >> w) & 64'd1) != 64'd0;
            end
        end
        r.o = (x[W-1] == y[W-1]) && (r.s[W-1] != x[W-1]);
        return r;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '1;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return '0;
            default: return $urandom();
        endcase
    endfunction

    task automatic drive_rand(input logic iv);
        in_valid = iv;
        a        = pick();
        b        = pick();
        cin      = 1'($urandom_range(0, 1));
`ifdef PADD_APPROX_EN
        ap       = 1'($urandom_range(0, 1));
`endif
    endtask

    task automatic pin_model(input res_t got, input res_t want, input string nm);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL model_%s: got %h expected %h", nm, got, want);
        end
    endtask

    // Single beat into an empty pipeline; checks latency and hand-computed result.
    task automatic directed(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tc,
                            input logic tx, input logic [W-1:0] es, input logic ec,
                            input logic eo, input string nm);
        int lat;
        @(posedge clk); #1;
        in_valid = 1'b1; a = ta; b = tbv; cin = tc; ap = tx; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat != int'(NSTG)) begin
            errors++;
            $display("FAIL %s_latency: got %0d expected %0d", nm, lat, NSTG);
        end
        checks++;
        if (sum !== es || cout !== ec || ovf !== eo) begin
            errors++;
            $display("FAIL %s_result: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                     nm, sum, cout, ovf, es, ec, eo);
        end
        @(posedge clk); #1;
        ap = 1'b0;
    endtask

    // Scoreboard and protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
        res_t e;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                errors++;
                $display("FAIL in_ready: got %b expected %b", in_ready, !out_valid || out_ready);
            end
            if (stall_prev) begin
                checks++;
                if (out_valid !== 1'b1 || {sum, cout, ovf} !== prev) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b %h expected v=1 %h",
                             out_valid, {sum, cout, ovf}, prev);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got sum=%h expected no beat", sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({sum, cout, ovf} !== e) begin
                        errors++;
                        $display("FAIL beat: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                                 sum, cout, ovf, e.s, e.c, e.o);
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, ap));
            stall_prev = out_valid && !out_ready;
            prev       = {sum, cout, ovf};
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int first, last, nvalid;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; ap = 1'b0; out_ready = 1'b1;

        pin_model(model(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0), {32'h0, 1'b1, 1'b0}, "wrap");
        pin_model(model(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0), {32'h8000_0000, 1'b0, 1'b1}, "ovf");
        pin_model(model(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0), {32'h0, 1'b1, 1'b1}, "negovf");
        pin_model(model(32'h0000_001F, 32'h1, 1'b0, 1'b1), {32'h0, 1'b0, 1'b0}, "approx");

        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || ovf !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got v=%b sum=%h c=%b o=%b rdy=%b expected 0 0 0 0 1",
                     out_valid, sum, cout, ovf, in_ready);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;

        directed(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, "carry_wrap");
        directed(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "signed_ovf");
        directed(32'h0000_001F, 32'h1, 1'b0, 1'b0, 32'h0000_0020, 1'b0, 1'b0, "chunk_carry");
`ifdef PADD_APPROX_EN
        directed(32'h0000_001F, 32'h1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, "approx_cut");
`endif

        // 20 back-to-back beats must emerge as 20 consecutive valid cycles
        first = -1; last = -1; nvalid = 0; out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            drive_rand(i < 20);
            @(negedge clk);
            if (out_valid) begin
                if (first < 0) first = i;
                last = i;
                nvalid++;
            end
        end
        checks++;
        if (nvalid != 20 || last - first + 1 != 20 || first != int'(NSTG)) begin
            errors++;
            $display("FAIL burst: got n=%0d first=%0d last=%0d expected n=20 first=%0d run=20",
                     nvalid, first, last, NSTG);
        end

        // Fill, stall for 5 cycles, then drain
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            out_ready = 1'b0;
            drive_rand(1'b1);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            drive_rand(1'b1);
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall: got rdy=%b v=%b expected rdy=0 v=1", in_ready, out_valid);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b0;
        repeat (12) @(posedge clk);

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            drive_rand($urandom_range(0, 2) != 0);
            out_ready = $urandom_range(0, 3) != 0;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (2 * NSTG + 4) @(posedge clk);

        // Reset with a full, stalled pipeline: everything in flight is discarded
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            out_ready = 1'b0;
            drive_rand(1'b1);
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        checks++;
        if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || ovf !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: got v=%b sum=%h c=%b o=%b rdy=%b expected 0 0 0 0 1",
                     out_valid, sum, cout, ovf, in_ready);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (2 * NSTG + 4) @(posedge clk);

        directed(32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0, 32'h9999_999A, 1'b0, 1'b0, "post_reset");
        repeat (NSTG + 2) @(posedge clk);

        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drained: got %0d pending expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
